// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the bus-mapped LED PWM controller.
package led_pwm_pkg;

  localparam int unsigned ENABLE_OFS     = 0;
  localparam int unsigned BLINK_MASK_OFS = 1;
  localparam int unsigned BLINK_HALF_OFS = 2;
  localparam int unsigned DUTY_BASE_OFS  = 3;

  localparam int BLINK_W    = 16;
  localparam int BUS_ADDR_W = 8;

  // Replace the byte lanes of old_val selected by be with those of new_val.
  function automatic logic [31:0] apply_byte_lanes(input logic [31:0] old_val,
                                                   input logic [31:0] new_val,
                                                   input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_controller_if.sv
// Peripheral bus seen by the LED controller: word-addressed, byte-lane writes,
// one-cycle registered reads.
interface led_pwm_controller_if;
  logic [led_pwm_pkg::BUS_ADDR_W-1:0] address;
  logic                               read_req;
  logic                               write_req;
  logic [3:0]                         byte_enable;
  logic [31:0]                        write_data;
  logic [31:0]                        read_data;
  logic                               read_data_valid;

  modport leader (
    output address, read_req, write_req, byte_enable, write_data,
    input  read_data, read_data_valid
  );

  modport follower (
    input  address, read_req, write_req, byte_enable, write_data,
    output read_data, read_data_valid
  );
endinterface

// File: rtl/led_pwm_timebase.sv
// Shared timebase: prescaler, free-running PWM counter and blink phase
// generator stepped once per PWM period.
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BLINK_W-1:0]  blink_half,
  input  logic                blink_restart,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                phase
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic                tick;
  logic                wrap;

  always_comb begin
    tick        = (presc_q == PS_W'(PRESCALE - 1));
    presc_d     = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    wrap        = tick && (pwm_cnt_q == '1);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    // A restart lands in the same cycle as the new half-period, so it wins.
    if (blink_restart || (blink_half == '0)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (wrap) begin
      if (blink_cnt_q == blink_half - 1'b1) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;
  assign phase   = phase_q;

endmodule

// File: rtl/led_pwm_controller.sv
// Bus-mapped LED controller: register file, bus decode, per-channel PWM
// compare with shared blink gating, and registered LED drive.
module led_pwm_controller
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  led_pwm_controller_if.follower bus,
  output logic [NUM_LEDS-1:0]   leds
);

  logic [NUM_LEDS-1:0] enable_q, enable_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [BLINK_W-1:0]  half_q, half_d;
  logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_d [NUM_LEDS];
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  logic [31:0]         addr;
  logic [31:0]         rd_mux;
  logic [31:0]         merged;
  logic                blink_restart;
  logic [NUM_LEDS-1:0] pwm_on;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase;
  logic                unused_merged;

  assign addr = 32'(bus.address);

  always_comb begin
    enable_d      = enable_q;
    mask_d        = mask_q;
    half_d        = half_q;
    duty_d        = duty_q;
    blink_restart = 1'b0;
    rd_mux        = '0;

    if (addr == ENABLE_OFS)          rd_mux = 32'(enable_q);
    else if (addr == BLINK_MASK_OFS) rd_mux = 32'(mask_q);
    else if (addr == BLINK_HALF_OFS) rd_mux = 32'(half_q);
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (addr == DUTY_BASE_OFS + 32'(i)) rd_mux = 32'(duty_q[i]);
    end

    // The read mux already holds the zero-extended current field, so it
    // doubles as the base for the byte-lane merge.
    merged = apply_byte_lanes(rd_mux, bus.write_data, bus.byte_enable);

    if (bus.write_req) begin
      if (addr == ENABLE_OFS)     enable_d = merged[NUM_LEDS-1:0];
      if (addr == BLINK_MASK_OFS) mask_d   = merged[NUM_LEDS-1:0];
      if (addr == BLINK_HALF_OFS) begin
        half_d        = merged[BLINK_W-1:0];
        blink_restart = 1'b1;
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (addr == DUTY_BASE_OFS + 32'(i)) duty_d[i] = merged[PWM_BITS-1:0];
      end
    end

    // Reads sample the pre-write register contents.
    rvalid_d = bus.read_req;
    rdata_d  = bus.read_req ? rd_mux : rdata_q;

    for (int i = 0; i < NUM_LEDS; i++) begin
      pwm_on[i] = (duty_q[i] > pwm_cnt) || (duty_q[i] == '1);
      leds_d[i] = enable_q[i] & pwm_on[i] & (~mask_q[i] | phase);
    end
  end

  assign unused_merged = ^merged;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      mask_q   <= '0;
      half_q   <= '0;
      duty_q   <= '{default: '0};
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      leds_q   <= '0;
    end else begin
      enable_q <= enable_d;
      mask_q   <= mask_d;
      half_q   <= half_d;
      duty_q   <= duty_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      leds_q   <= leds_d;
    end
  end

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .blink_half    (half_q),
    .blink_restart (blink_restart),
    .pwm_cnt       (pwm_cnt),
    .phase         (phase)
  );

  assign bus.read_data       = rdata_q;
  assign bus.read_data_valid = rvalid_q;
  assign leds                = leds_q;

endmodule

// File: tb/tb_led_pwm_controller.sv
// Directed bench for led_pwm_controller: an 8-bit PWM instance for register,
// reset and duty behaviour, and a 4-bit PWM instance for blink timing.
module tb_led_pwm_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pwm_controller_if bus_a ();
  led_pwm_controller_if bus_b ();

  logic        wr_req [2];
  logic        rd_req [2];
  logic [7:0]  addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  be     [2];

  assign bus_a.write_req   = wr_req[0];
  assign bus_a.read_req    = rd_req[0];
  assign bus_a.address     = addr[0];
  assign bus_a.write_data  = wdata[0];
  assign bus_a.byte_enable = be[0];
  assign bus_b.write_req   = wr_req[1];
  assign bus_b.read_req    = rd_req[1];
  assign bus_b.address     = addr[1];
  assign bus_b.write_data  = wdata[1];
  assign bus_b.byte_enable = be[1];

  logic [3:0] leds_a, leds_b;

  led_pwm_controller #(.NUM_LEDS(4), .PWM_BITS(8), .PRESCALE(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .leds  (leds_a)
  );

  led_pwm_controller #(.NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .leds  (leds_b)
  );

  int passed = 0;
  int total  = 0;
  int led0_low = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic bus_write(input int s, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] b);
    @(negedge clk);
    wr_req[s] = 1'b1; addr[s] = a; wdata[s] = d; be[s] = b;
    @(negedge clk);
    wr_req[s] = 1'b0; be[s] = 4'h0;
  endtask

  task automatic read_check(input int s, input logic [7:0] a, input logic [31:0] exp,
                            input string tag);
    @(negedge clk);
    rd_req[s] = 1'b1; addr[s] = a;
    @(negedge clk);
    rd_req[s] = 1'b0;
    if (s == 0) begin
      check({tag, ".vld"}, 32'(bus_a.read_data_valid), 32'd1);
      check(tag, bus_a.read_data, exp);
    end else begin
      check({tag, ".vld"}, 32'(bus_b.read_data_valid), 32'd1);
      check(tag, bus_b.read_data, exp);
    end
  endtask

  task automatic count_high(input int s, input int ch, input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if ((s == 0 ? leds_a[ch] : leds_b[ch]) === 1'b1) n++;
    end
  endtask

  // Cycles until leds_b[1] changes, or -1 if it holds for the whole bound.
  task automatic wait_change(input int bound, output int n);
    logic start;
    start = leds_b[1];
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (leds_b[0] !== 1'b1) led0_low++;
      if (leds_b[1] !== start) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int s = 0; s < 2; s++) begin
      wr_req[s] = 1'b0; rd_req[s] = 1'b0; addr[s] = 8'd0; wdata[s] = 32'd0; be[s] = 4'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("init.leds", 32'(leds_a), 32'd0);
    check("init.vld", 32'(bus_a.read_data_valid), 32'd0);
    check("init.rdata", bus_a.read_data, 32'd0);
    check("init.phase", 32'(dut_a.u_timebase.phase_q), 32'd1);

    // Populate registers, then reset with a read in flight.
    bus_write(0, 8'd0, 32'hF, 4'hF);
    bus_write(0, 8'd3, 32'hFF, 4'hF);
    bus_write(0, 8'd1, $urandom & 32'hE, 4'hF);
    bus_write(0, 8'd2, $urandom, 4'hF);
    bus_write(0, 8'd4, $urandom, 4'hF);
    repeat (2) @(negedge clk);
    check("pre_rst.led0", 32'(leds_a[0]), 32'd1);
    rd_req[0] = 1'b1; addr[0] = 8'd0; reset = 1'b1;
    @(negedge clk);
    rd_req[0] = 1'b0;
    check("rst.rd_suppress", 32'(bus_a.read_data_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.leds", 32'(leds_a), 32'd0);
    check("rst.vld_after", 32'(bus_a.read_data_valid), 32'd0);
    check("rst.phase", 32'(dut_a.u_timebase.phase_q), 32'd1);
    for (int o = 0; o < 7; o++) read_check(0, 8'(o), 32'd0, $sformatf("rst.reg%0d", o));

    // Register access and byte lanes.
    bus_write(0, 8'd0, 32'hF, 4'h0);
    read_check(0, 8'd0, 32'h0, "en.be0");
    bus_write(0, 8'd0, 32'hF, 4'h1);
    read_check(0, 8'd0, 32'hF, "en.be1");
    @(negedge clk);
    check("vld.one_cycle", 32'(bus_a.read_data_valid), 32'd0);
    bus_write(0, 8'd7, 32'hFF, 4'hF);
    read_check(0, 8'd7, 32'h0, "unmapped");
    bus_write(0, 8'd0, 32'hFFFF_FFFF, 4'hF);
    read_check(0, 8'd0, 32'hF, "en.width");
    bus_write(0, 8'd2, 32'h1234_ABCD, 4'h2);
    read_check(0, 8'd2, 32'hAB00, "half.lane1");
    bus_write(0, 8'd2, 32'h0000_00CD, 4'h1);
    read_check(0, 8'd2, 32'hABCD, "half.lane0");
    bus_write(0, 8'd2, 32'h0, 4'hF);

    // PWM duty on channel 0.
    bus_write(0, 8'd0, 32'h1, 4'hF);
    bus_write(0, 8'd3, 32'd64, 4'hF);
    repeat (2) @(negedge clk);
    count_high(0, 0, 256, n);
    check("pwm.duty64", 32'(n), 32'd64);
    bus_write(0, 8'd3, 32'd0, 4'hF);
    repeat (2) @(negedge clk);
    count_high(0, 0, 256, n);
    check("pwm.duty0", 32'(n), 32'd0);
    bus_write(0, 8'd3, 32'd255, 4'hF);
    repeat (2) @(negedge clk);
    count_high(0, 0, 256, n);
    check("pwm.duty255", 32'(n), 32'd256);

    // Blink on the 4-bit instance.
    bus_write(1, 8'd3, 32'hFF, 4'hF);
    read_check(1, 8'd3, 32'hF, "b.duty_width");
    bus_write(1, 8'd4, 32'hF, 4'hF);
    bus_write(1, 8'd0, 32'h3, 4'hF);
    bus_write(1, 8'd1, 32'h2, 4'hF);
    bus_write(1, 8'd2, 32'h2, 4'hF);
    led0_low = 0;
    wait_change(64, n);
    check("blink.first", 32'((n > 0) && (n <= 64)), 32'd1);
    wait_change(64, n);
    check("blink.low_run", 32'(n), 32'd32);
    wait_change(64, n);
    check("blink.high_run", 32'(n), 32'd32);
    check("blink.led0_steady", 32'(led0_low), 32'd0);
    check("blink.phase0", 32'(leds_b[1]), 32'd0);

    // Rewriting the half-period restarts the phase high.
    bus_write(1, 8'd2, 32'h2, 4'hF);
    check("rewrite.lag", 32'(leds_b[1]), 32'd0);
    @(negedge clk);
    check("rewrite.high", 32'(leds_b[1]), 32'd1);
    bus_write(1, 8'd2, 32'h0, 4'hF);
    count_high(1, 1, 100, n);
    check("half0.steady", 32'(n), 32'd100);

    // Same-cycle read and write to DUTY[2].
    bus_write(0, 8'd5, 32'd10, 4'hF);
    @(negedge clk);
    rd_req[0] = 1'b1; wr_req[0] = 1'b1; addr[0] = 8'd5; wdata[0] = 32'd200; be[0] = 4'hF;
    @(negedge clk);
    rd_req[0] = 1'b0; wr_req[0] = 1'b0; be[0] = 4'h0;
    check("rw.vld", 32'(bus_a.read_data_valid), 32'd1);
    check("rw.old", bus_a.read_data, 32'd10);
    read_check(0, 8'd5, 32'd200, "rw.new");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
